bomb_controller: RTL

Places a single bomb on the tile grid at the player's position and runs its fuse, blast and idle sequence. It produces the explosion coordinates and the one-cycle explosion pulse (`e_x`, `e_y`, `explosion_SCEN`) that the enemy and player modules use for kill detection. It also drives the bomb and explosion pixel flags that the top module uses for VGA compositing. It sits directly upstream of every enemy instance.

---
 rtl/bomb_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bomb_controller.sv
// Single-bomb placement, fuse/blast sequencing, explosion pulse and pixel flags.
// Optional remote detonation is enabled with the BOMB_REMOTE_DETONATE_EN macro.
module bomb_controller #(
   parameter int unsigned FUSE_TICKS  = 100_000_000,
   parameter int unsigned BLAST_TICKS = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       drop,
   input  logic       detonate,
   input  logic [9:0] b_x,
   input  logic [9:0] b_y,
   input  logic [9:0] v_x,
   input  logic [9:0] v_y,
   output logic [9:0] e_x,
   output logic [9:0] e_y,
   output logic       explosion_SCEN,
   output logic       bomb_active,
   output logic       bomb_on,
   output logic       explosion_on
);
   localparam int unsigned CW = 27;
   localparam int unsigned PW = 10;
   localparam int unsigned AW = 11;

   localparam logic [AW-1:0] MIN_X   = AW'(143);
   localparam logic [AW-1:0] MIN_Y   = AW'(34);
   localparam logic [AW-1:0] MAX_COL = AW'(39);
   localparam logic [AW-1:0] MAX_ROW = AW'(29);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      BLAST = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          drop_q, drop_edge;
   logic          load, scen_next;
   logic          fuse_done, blast_done, early;
   logic [PW-1:0] snap_x, snap_y;

   // Round a pixel position to the nearest tile origin, clamped to the grid.
   function automatic logic [PW-1:0] snap(input logic [PW-1:0] pos,
                                          input logic [AW-1:0] base,
                                          input logic [AW-1:0] lim);
      logic [AW-1:0] sum;
      logic [AW-1:0] idx;
      sum = {1'b0, pos} + AW'(8);
      idx = (sum < base) ? '0 : ((sum - base) >> 4);
      if (idx > lim) idx = lim;
      return PW'(base + (idx << 4));
   endfunction

   assign snap_x     = snap(b_x, MIN_X, MAX_COL);
   assign snap_y     = snap(b_y, MIN_Y, MAX_ROW);
   assign drop_edge  = drop & ~drop_q;
   assign fuse_done  = (cnt == CW'(FUSE_TICKS - 1));
   assign blast_done = (cnt == CW'(BLAST_TICKS - 1));

`ifdef BOMB_REMOTE_DETONATE_EN
   assign early = detonate;
`else
   logic unused_detonate;
   assign early           = 1'b0;
   assign unused_detonate = detonate;
`endif

   // State register and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         drop_q         <= 1'b0;
         e_x            <= '0;
         e_y            <= '0;
         explosion_SCEN <= 1'b0;
         bomb_active    <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         drop_q         <= drop;
         explosion_SCEN <= scen_next;
         bomb_active    <= (state_next != IDLE);
         if (load) begin
            e_x <= snap_x;
            e_y <= snap_y;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      cnt_next   = cnt + CW'(1);
      load       = 1'b0;
      scen_next  = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (drop_edge) begin
               state_next = ARMED;
               load       = 1'b1;
            end
         end
         ARMED: begin
            if (fuse_done || early) begin
               state_next = BLAST;
               cnt_next   = '0;
               scen_next  = 1'b1;
            end
         end
         BLAST: begin
            if (blast_done) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   logic [AW-1:0] ex, ey, vx, vy;
   logic          in_col, in_row, h_arm, v_arm;

   assign ex = {1'b0, e_x};
   assign ey = {1'b0, e_y};
   assign vx = {1'b0, v_x};
   assign vy = {1'b0, v_y};

   // Pixel flags: bomb tile while armed, 16-px-wide cross while blasting
   always_comb begin
      in_col       = (vx >= ex) && (vx <= ex + AW'(15));
      in_row       = (vy >= ey) && (vy <= ey + AW'(15));
      h_arm        = in_row && (vx + AW'(48) >= ex) && (vx <= ex + AW'(63));
      v_arm        = in_col && (vy + AW'(48) >= ey) && (vy <= ey + AW'(63));
      bomb_on      = (state == ARMED) && in_col && in_row;
      explosion_on = (state == BLAST) && (h_arm || v_arm);
   end

endmodule
